// File: rtl/ldunit.sv
// Load unit: accepts one load at a time, issues a single word-aligned read,
// waits for the returned word, then extracts and zero/sign-extends the
// addressed byte, half-word or word. Misaligned or illegal requests are
// answered with an error response without touching memory.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. req_ready is high only in IDLE; rsp_valid is high only in
// RESP, and rsp_data/rsp_err hold steady until rsp_ready is seen there.
// Every output is a flop or a decode of the state register, so no input
// reaches an output combinationally.
module ldunit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rd_valid,
  input  logic [31:0]           mem_rd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  misaligned;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           extracted;

  // Classify the incoming request: wrong alignment for its size, or size 11.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Select the addressed field from the returned word and extend it to 32 bits.
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    extracted = mem_rd_data;
    case (lane_q)
      2'd0:    byte_sel = mem_rd_data[7:0];
      2'd1:    byte_sel = mem_rd_data[15:8];
      2'd2:    byte_sel = mem_rd_data[23:16];
      default: byte_sel = mem_rd_data[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    case (size_q)
      2'b00:   extracted = {{24{sgn_q & byte_sel[7]}}, byte_sel};
      2'b01:   extracted = {{16{sgn_q & half_sel[15]}}, half_sel};
      default: extracted = mem_rd_data;
    endcase
  end

  // Next-state and datapath register updates for the four-state load sequence.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lane_d     = req_addr[1:0];
          size_d     = req_size;
          sgn_d      = req_signed;
          mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (misaligned) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = 32'h0;
            state_d    = S_RESP;
          end else begin
            rsp_err_d  = 1'b0;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // The read strobe is decoded from this state; memory data is ignored here.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_valid) begin
          rsp_data_d = extracted;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any load in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lane_q     <= 2'b00;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      mem_addr_q <= '0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      mem_addr_q <= mem_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_rd_en = (state_q == S_ISSUE);
  assign rsp_valid = (state_q == S_RESP);
  assign mem_addr  = mem_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ldunit.sv
// Bench for ldunit: directed loads against a fixed memory word, with a
// scoreboard queue of expected {err, data} responses checked by a monitor.
module tb_ldunit;

  localparam logic [31:0] MEM_WORD = 32'h788EFD0C;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  ldunit #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare each new response against the head of the expected queue.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rsp_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {rsp_err, rsp_data}, 33'h0);
        if ({rsp_err, rsp_data} == 33'h0) begin
          n_pass--;
          $display("FAIL rsp_unexpected: got response expected none");
        end
      end else begin
        check("rsp_value", {rsp_err, rsp_data}, exp_q.pop_front());
      end
    end
    prev_valid = rsp_valid;
  end

  // Driver: issue one load just after a falling edge, play memory with the
  // given delay, hold rsp_ready low for `hold` cycles, then complete.
  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                         input int delay, input int hold, input logic stray,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int lat;
    int rd_cnt;
    logic [32:0] held;
    lat    = 0;
    rd_cnt = 0;
    check("req_ready_before", {32'h0, req_ready}, 33'h1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    exp_q.push_back({exp_err, exp_data});
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
      end
      if (rsp_valid) begin
        lat = k;
        mem_rd_valid = 1'b0;
        break;
      end
      if (mem_rd_en) begin
        rd_cnt++;
        check("mem_addr", {1'b0, mem_addr}, {1'b0, addr[31:2], 2'b00});
      end
      if (!exp_err && k == 1 + delay) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = MEM_WORD;
      end else if (!exp_err && k == 1 && delay > 1) begin
        // Stray valid while the read is still being issued must be ignored.
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hDEADBEEF;
      end else begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = $urandom;
      end
    end
    check("rsp_latency", 33'(lat), 33'(exp_lat));
    check("rd_en_count", 33'(rd_cnt), exp_err ? 33'd0 : 33'd1);
    held = {rsp_err, rsp_data};
    for (int h = 0; h < hold; h++) begin
      if (stray && h == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = ~MEM_WORD;
      end else begin
        mem_rd_valid = 1'b0;
      end
      @(negedge clk);
      check("hold_stable", {rsp_err, rsp_data}, held);
      check("hold_req_ready", {31'h0, req_ready, rsp_valid}, 33'h1);
    end
    mem_rd_valid = 1'b0;
    rsp_ready    = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("after_handshake", {31'h0, req_ready, rsp_valid}, 33'h2);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_size     = 2'b00;
    req_signed   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = 32'h0;
    rsp_ready    = 1'b0;

    // Reset and idle
    @(negedge clk);
    check("reset_outputs", {rsp_data, rsp_err}, 33'h0);
    check("reset_ctrl", {29'h0, req_ready, mem_rd_en, rsp_valid, 1'b0}, 33'h8);
    check("reset_mem_addr", {1'b0, mem_addr}, 33'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ctrl", {30'h0, req_ready, mem_rd_en, rsp_valid}, 33'h4);
    end

    // Half-word loads
    do_load(32'h100, 2'b01, 1'b0, 1, 0, 1'b0, 32'h0000FD0C, 1'b0, 3);
    do_load(32'h100, 2'b01, 1'b1, 1, 0, 1'b0, 32'hFFFFFD0C, 1'b0, 3);
    do_load(32'h102, 2'b01, 1'b1, 1, 0, 1'b0, 32'h0000788E, 1'b0, 3);
    // Byte and word loads
    do_load(32'h101, 2'b00, 1'b1, 1, 0, 1'b0, 32'hFFFFFFFD, 1'b0, 3);
    do_load(32'h103, 2'b00, 1'b0, 1, 0, 1'b0, 32'h00000078, 1'b0, 3);
    do_load(32'h102, 2'b00, 1'b1, 1, 0, 1'b0, 32'hFFFFFF8E, 1'b0, 3);
    do_load(32'h100, 2'b00, 1'b0, 1, 0, 1'b0, 32'h0000000C, 1'b0, 3);
    do_load(32'h100, 2'b10, 1'b0, 1, 0, 1'b0, 32'h788EFD0C, 1'b0, 3);
    do_load(32'h100, 2'b10, 1'b1, 1, 0, 1'b0, 32'h788EFD0C, 1'b0, 3);
    // Errors
    do_load(32'h101, 2'b01, 1'b0, 1, 0, 1'b0, 32'h0, 1'b1, 1);
    do_load(32'h100, 2'b11, 1'b0, 1, 0, 1'b0, 32'h0, 1'b1, 1);
    do_load(32'h102, 2'b10, 1'b1, 1, 2, 1'b0, 32'h0, 1'b1, 1);
    // Slow memory, backpressure with stray memory valid, back-to-back request
    do_load(32'h102, 2'b01, 1'b0, 5, 0, 1'b0, 32'h0000788E, 1'b0, 7);
    do_load(32'h101, 2'b00, 1'b0, 2, 4, 1'b1, 32'h000000FD, 1'b0, 4);
    do_load(32'h103, 2'b00, 1'b1, 1, 0, 1'b0, 32'h00000078, 1'b0, 3);

    // Reset while waiting for memory
    req_valid = 1'b1;
    req_addr  = 32'h100;
    req_size  = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("in_wait", {31'h0, dbg_state}, 33'h2);
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {30'h0, req_ready, mem_rd_en, rsp_valid}, 33'h4);
    check("midreset_state", {31'h0, dbg_state}, 33'h0);
    @(negedge clk);
    rst_n        = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd_data  = MEM_WORD;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_reset_idle", {30'h0, req_ready, mem_rd_en, rsp_valid}, 33'h4);
    end

    // Recovery load after the abort
    do_load(32'h102, 2'b01, 1'b0, 1, 0, 1'b0, 32'h0000788E, 1'b0, 3);

    repeat (3) @(negedge clk);
    check("queue_empty", 33'(exp_q.size()), 33'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
